jtag_scan_ctrl: RTL
===================

// Module: jtag_scan_ctrl
//
// PURPOSE
//   Instruction/data-register scan controller that sits behind the jtag TAP state machine.
//   - Consumes one-hot TAP state strobes.
//   - Owns the IR shift/hold registers and decodes the current instruction.
//   - Selects, captures, shifts and updates the active DR: IDCODE, BYPASS or an 8-bit USER register.
//   - Drives TDO, and hands USER data and ABORT events to the main design.
//
// PARAMETERS
//   IR_WIDTH       4             instruction register width
//   IDCODE_VALUE   32'h000FAF01  value captured into the IDCODE DR
//   USER_DR_WIDTH  8             USER DR width; legal range 1..32
//   INSTR_ABORT    4'b1000       ABORT opcode
//   INSTR_IDCODE   4'b1110       IDCODE opcode; also the reset value of the IR
//   INSTR_BYPASS   4'b1111       BYPASS opcode
//   INSTR_USER     4'b1010       USER opcode
//
// PORTS
//   tck           in   1         JTAG clock; all logic on posedge
//   trst_n        in   1         asynchronous active-low reset
//   tlr           in   1         TAP is in Test-Logic-Reset
//   capture_ir    in   1         TAP in Capture-IR
//   shift_ir      in   1         TAP in Shift-IR
//   update_ir     in   1         TAP in Update-IR
//   capture_dr    in   1         TAP in Capture-DR
//   shift_dr      in   1         TAP in Shift-DR
//   update_dr     in   1         TAP in Update-DR
//   tdi           in   1         serial data in
//   user_dr_in    in   UDW       parallel value captured into USER DR
//   tdo           out  1         registered serial data out
//   tdo_en        out  1         high while tdo carries shifted data
//   ir            out  IR_WIDTH  current (updated) instruction
//   user_dr_out   out  UDW       last USER DR value applied by Update-DR
//   user_update   out  1         1-cycle pulse when user_dr_out is written
//   abort_pulse   out  1         1-cycle pulse when ABORT is loaded into the IR
//
// BEHAVIOUR
//   Reset: trst_n low clears asynchronously, immediately.
//     - ir = INSTR_IDCODE.
//     - ir_shift, dr_shift[31:0], bypass_bit, tdo, tdo_en, user_dr_out, user_update, abort_pulse = 0.
//   tlr high: applies the same values synchronously on the next edge.
//   Strobe priority: tlr > capture_* > shift_* > update_*; the IR strobe wins over the DR strobe.
//     The TAP guarantees one-hot strobes; the priority only defines illegal input combinations.
//   DR select (combinational from ir):
//     - IDCODE -> 32-bit dr_shift.
//     - USER -> dr_shift[UDW-1:0].
//     - ABORT, BYPASS and any other opcode -> bypass_bit.
//   capture_ir: ir_shift <= {0..., 2'b01}, i.e. 4'b0001 (IEEE 1149.1 capture pattern).
//   shift_ir:
//     - tdo <= ir_shift[0], tdo_en <= 1.
//     - ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
//   update_ir:
//     - ir <= ir_shift.
//     - abort_pulse <= (ir_shift == INSTR_ABORT) for exactly one cycle.
//   capture_dr:
//     - IDCODE: dr_shift <= IDCODE_VALUE.
//     - USER: dr_shift[UDW-1:0] <= user_dr_in; upper bits <= 0.
//     - Bypass: bypass_bit <= 0.
//   shift_dr: LSB first. tdo <= bit 0 of the selected DR, tdo_en <= 1.
//     - IDCODE: tdi enters at bit 31.
//     - USER: tdi enters at bit UDW-1.
//     - Bypass: tdo <= bypass_bit, bypass_bit <= tdi (one cycle of delay).
//   update_dr:
//     - USER selected: user_dr_out <= dr_shift[UDW-1:0] and user_update pulses for one cycle.
//     - Otherwise no state change.
//   Other cycles:
//     - tdo <= 0, tdo_en <= 0; pulses return to 0.
//     - ir, user_dr_out and shift registers hold.
//   Latency: every output is registered and changes on the tck edge that samples the strobe.
//     The first shifted bit appears on tdo after the first shift edge.
//   Bit counting is left to the host. Shifting more than the DR length recirculates tdi bits.
//     No wrap or overflow check is performed.
//   The IR changes only on update_ir (or reset/tlr), so the DR select is stable across a whole DR scan.
//   Reset mid-scan: partial shift data is discarded and user_dr_out returns to 0.
//
// TESTING
//   1 Reset; capture_dr, then 32 shift_dr with tdi=0
//     -> tdo bits LSB-first = 32'h000FAF01, tdo_en high for exactly 32 cycles.
//   2 capture_ir, shift_ir x4 with tdi=1,1,1,1, update_ir
//     -> tdo=1,0,0,0 and ir=4'b1111.
//     Then capture_dr, shift_dr tdi=1,0,1 -> tdo=0,1,0.
//   3 Load ir=4'b1010; capture_dr with user_dr_in=8'hA5; shift 8 bits of 8'h3C LSB-first; update_dr
//     -> tdo emits A5 LSB-first, user_dr_out=8'h3C, user_update high for exactly one cycle.
//   4 Load ir=4'b1000 -> abort_pulse high for one cycle after update_ir; DR scan behaves as bypass.
//     Load ir=4'b0011 -> bypass as well, ir reads 4'b0011.
//   5 With ir=USER and user_dr_out=8'h3C, assert tlr for one cycle
//     -> ir=4'b1110, user_dr_out=0, tdo=0.
//   6 Pull trst_n low between tck edges mid-shift_dr
//     -> all outputs cleared before the next edge, ir=4'b1110.

Source files
------------

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: owns the IR, selects/captures/shifts/updates IDCODE, BYPASS or USER DR.
// All state runs on posedge tck; driven by one-hot TAP state strobes.
module jtag_scan_ctrl #(
  parameter int                    IR_WIDTH      = 4,
  parameter logic [31:0]           IDCODE_VALUE  = 32'h000FAF01,
  parameter int                    USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0]   INSTR_ABORT   = 4'b1000,
  parameter logic [IR_WIDTH-1:0]   INSTR_IDCODE  = 4'b1110,
  parameter logic [IR_WIDTH-1:0]   INSTR_BYPASS  = 4'b1111,
  parameter logic [IR_WIDTH-1:0]   INSTR_USER    = 4'b1010
) (
  input  logic                     tck,
  input  logic                     trst_n,
  input  logic                     tlr,
  input  logic                     capture_ir,
  input  logic                     shift_ir,
  input  logic                     update_ir,
  input  logic                     capture_dr,
  input  logic                     shift_dr,
  input  logic                     update_dr,
  input  logic                     tdi,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [IR_WIDTH-1:0]      ir,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update,
  output logic                     abort_pulse
);

  localparam int UDW = USER_DR_WIDTH;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         dr_shift;
  logic                bypass_bit;

  logic                sel_idcode;
  logic                sel_user;
  logic [UDW-1:0]      user_shifted;
  logic [31:0]         dr_user_next;

  assign sel_idcode = (ir == INSTR_IDCODE);
  assign sel_user   = (ir == INSTR_USER);

  // USER shifts only the low UDW bits; upper dr_shift bits are left untouched.
  always_comb begin
    user_shifted          = dr_shift[UDW-1:0] >> 1;
    user_shifted[UDW-1]   = tdi;
    dr_user_next          = dr_shift;
    dr_user_next[UDW-1:0] = user_shifted;
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir          <= INSTR_IDCODE;
      ir_shift    <= '0;
      dr_shift    <= '0;
      bypass_bit  <= 1'b0;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_dr_out <= '0;
      user_update <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_update <= 1'b0;
      abort_pulse <= 1'b0;
      if (tlr) begin
        ir          <= INSTR_IDCODE;
        ir_shift    <= '0;
        dr_shift    <= '0;
        bypass_bit  <= 1'b0;
        user_dr_out <= '0;
      end else if (capture_ir) begin
        ir_shift <= IR_CAPTURE;
      end else if (capture_dr) begin
        if (sel_idcode)    dr_shift   <= IDCODE_VALUE;
        else if (sel_user) dr_shift   <= 32'(user_dr_in);
        else               bypass_bit <= 1'b0;
      end else if (shift_ir) begin
        tdo      <= ir_shift[0];
        tdo_en   <= 1'b1;
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      end else if (shift_dr) begin
        tdo_en <= 1'b1;
        if (sel_idcode) begin
          tdo      <= dr_shift[0];
          dr_shift <= {tdi, dr_shift[31:1]};
        end else if (sel_user) begin
          tdo      <= dr_shift[0];
          dr_shift <= dr_user_next;
        end else begin
          tdo        <= bypass_bit;
          bypass_bit <= tdi;
        end
      end else if (update_ir) begin
        ir          <= ir_shift;
        abort_pulse <= (ir_shift == INSTR_ABORT);
      end else if (update_dr) begin
        if (sel_user) begin
          user_dr_out <= dr_shift[UDW-1:0];
          user_update <= 1'b1;
        end
      end
    end
  end

endmodule
